channel_in: RTL and testbench

Receive-side decoder for the NeoPixel (WS2812-style) single-wire bit code: the counterpart of the channel output encoder. Samples an incoming bit stream, classifies each high pulse as 0 or 1 against a programmable threshold, packs bits MSB-first into G/R/B bytes and writes them into pixel RAM using the same byte-lane write format the output channel consumes. Detects the line reset/latch interval and reports frame completion. Used for loopback test and for chaining/capturing upstream LED data.

---
 rtl/channel_in.sv | 205 ++++++++++++++++++++
 tb/tb_channel_in.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/channel_in.sv
`default_nettype none
// channel_in: NeoPixel single-wire receive decoder; packs G/R/B bytes MSB-first into pixel RAM writes.
// Optional macro CHANNEL_IN_GLITCH_FILTER_EN rejects line pulses/gaps shorter than 3 clk.
module channel_in (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        bit_code_i,
  input  logic [7:0]  reg_bit_thr_i,
  input  logic [15:0] reg_rst_time_i,
  output logic        ram_wr_en_o,
  output logic [7:0]  ram_wr_addr_o,
  output logic [7:0]  ram_wr_data_o,
  output logic [3:0]  ram_wr_byte_en_o,
  output logic        ram_wr_done_o,
  output logic        overflow_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  logic [1:0] sync;
  logic       level;
  logic       rise;
  logic       fall;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync <= 2'b00;
    else       sync <= {sync[0], bit_code_i};
  end

`ifdef CHANNEL_IN_GLITCH_FILTER_EN
  // level only follows the line after three equal synchronized samples
  logic [1:0] hist;
  logic       all_hi;
  logic       all_lo;

  assign all_hi = sync[1] & hist[0] & hist[1];
  assign all_lo = ~(sync[1] | hist[0] | hist[1]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hist  <= 2'b00;
      level <= 1'b0;
    end else begin
      hist <= {hist[0], sync[1]};
      if (all_hi)      level <= 1'b1;
      else if (all_lo) level <= 1'b0;
    end
  end

  assign rise = all_hi & ~level;
  assign fall = all_lo & level;
`else
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) level <= 1'b0;
    else       level <= sync[1];
  end

  assign rise = sync[1] & ~level;
  assign fall = ~sync[1] & level;
`endif

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n, cnt_inc, rst_time_eff;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [1:0]  byte_idx, byte_idx_n;
  logic [7:0]  shift, shift_n, byte_val;
  logic [7:0]  addr, addr_n;
  logic        full, full_n;
  logic        got_bit, got_bit_n;
  logic        bit_val;
  logic        wr_en, wr_en_n;
  logic [7:0]  wr_addr, wr_addr_n;
  logic [7:0]  wr_data, wr_data_n;
  logic [3:0]  wr_be, wr_be_n;
  logic        done, done_n;
  logic        ovf, ovf_n;

  assign cnt_inc      = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  assign rst_time_eff = (reg_rst_time_i == 16'd0) ? 16'd1 : reg_rst_time_i;
  assign bit_val      = (cnt >= {8'd0, reg_bit_thr_i});
  assign byte_val     = {shift[6:0], bit_val};

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_idx_n  = bit_idx;
    byte_idx_n = byte_idx;
    shift_n    = shift;
    addr_n     = addr;
    full_n     = full;
    got_bit_n  = got_bit;
    wr_en_n    = 1'b0;
    wr_addr_n  = 8'd0;
    wr_data_n  = 8'd0;
    wr_be_n    = 4'd0;
    done_n     = 1'b0;
    ovf_n      = ovf;
    case (state)
      IDLE: begin
        if (rise) begin
          state_n = HIGH;
          cnt_n   = 16'd1;
          ovf_n   = 1'b0;
        end
      end
      HIGH: begin
        cnt_n = cnt_inc;
        if (fall) begin
          state_n   = LOW;
          cnt_n     = 16'd1;
          shift_n   = byte_val;
          bit_idx_n = bit_idx + 3'd1;
          got_bit_n = 1'b1;
          if (bit_idx == 3'd7) begin
            // once pixel 255 lane B is written, remaining bytes only flag overflow
            if (full) begin
              ovf_n = 1'b1;
            end else begin
              wr_en_n   = 1'b1;
              wr_addr_n = addr;
              wr_data_n = byte_val;
              case (byte_idx)
                2'd0:    wr_be_n = 4'b0100;
                2'd1:    wr_be_n = 4'b0010;
                default: wr_be_n = 4'b0001;
              endcase
              if (byte_idx == 2'd2) begin
                byte_idx_n = 2'd0;
                if (addr == 8'hFF) full_n = 1'b1;
                else               addr_n = addr + 8'd1;
              end else begin
                byte_idx_n = byte_idx + 2'd1;
              end
            end
          end
        end
      end
      LOW: begin
        cnt_n = cnt_inc;
        if (rise) begin
          state_n = HIGH;
          cnt_n   = 16'd1;
        end else if (cnt >= rst_time_eff) begin
          state_n    = IDLE;
          cnt_n      = 16'd0;
          done_n     = got_bit;
          got_bit_n  = 1'b0;
          addr_n     = 8'd0;
          byte_idx_n = 2'd0;
          bit_idx_n  = 3'd0;
          shift_n    = 8'd0;
          full_n     = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= 16'd0;
      bit_idx  <= 3'd0;
      byte_idx <= 2'd0;
      shift    <= 8'd0;
      addr     <= 8'd0;
      full     <= 1'b0;
      got_bit  <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= 8'd0;
      wr_data  <= 8'd0;
      wr_be    <= 4'd0;
      done     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_idx_n;
      byte_idx <= byte_idx_n;
      shift    <= shift_n;
      addr     <= addr_n;
      full     <= full_n;
      got_bit  <= got_bit_n;
      wr_en    <= wr_en_n;
      wr_addr  <= wr_addr_n;
      wr_data  <= wr_data_n;
      wr_be    <= wr_be_n;
      done     <= done_n;
      ovf      <= ovf_n;
    end
  end

  assign ram_wr_en_o      = wr_en;
  assign ram_wr_addr_o    = wr_addr;
  assign ram_wr_data_o    = wr_data;
  assign ram_wr_byte_en_o = wr_be;
  assign ram_wr_done_o    = done;
  assign overflow_o       = ovf;

endmodule
`default_nettype wire

// File: tb/tb_channel_in.sv
`default_nettype none
// tb_channel_in: randomized NeoPixel frames checked against a bit-list reference model.
module tb_channel_in;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        line = 1'b0;
  logic [7:0]  thr = 8'd4;
  logic [15:0] rt = 16'd64;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [3:0]  wr_be;
  logic        done;
  logic        ovf;

  channel_in dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .bit_code_i       (line),
    .reg_bit_thr_i    (thr),
    .reg_rst_time_i   (rt),
    .ram_wr_en_o      (wr_en),
    .ram_wr_addr_o    (wr_addr),
    .ram_wr_data_o    (wr_data),
    .ram_wr_byte_en_o (wr_be),
    .ram_wr_done_o    (done),
    .overflow_o       (ovf)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          fails = 0;
  int          got_done = 0;
  int          exp_done = 0;
  int          overlap = 0;
  logic [19:0] exp_q[$];
  logic [19:0] got_q[$];
  bit          bits[$];
  bit          exp_ovf = 1'b0;

  always @(negedge clk) begin
    if (wr_en) got_q.push_back({wr_addr, wr_data, wr_be});
    if (done) got_done++;
    if (wr_en && done) overlap++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: every 8 bits form a byte; byte k goes to pixel k/3, lane k%3 (G,R,B).
  task automatic model(input bit complete);
    int         nbytes;
    int         pix;
    logic [7:0] b;
    nbytes = bits.size() / 8;
    for (int k = 0; k < nbytes; k++) begin
      b = 8'd0;
      for (int j = 0; j < 8; j++) b = {b[6:0], bits[k*8+j]};
      pix = k / 3;
      if (pix < 256) exp_q.push_back({pix[7:0], b, 4'b0100 >> (k % 3)});
    end
    if (complete && bits.size() > 0) exp_done++;
    exp_ovf = complete && (nbytes > 768);
  endtask

  task automatic check_frame(input string tag);
    int n;
    chk({tag, "_nwr"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_wr%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    chk({tag, "_done"}, 32'(got_done), 32'(exp_done));
    chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic add_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) bits.push_back(v[i]);
  endtask

  task automatic add_rand_bits(input int n);
    for (int i = 0; i < n; i++) bits.push_back($urandom_range(1, 0) == 1);
  endtask

  task automatic pulse(input int h, input int l);
    line = 1'b1;
    repeat (h) @(negedge clk);
    line = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic send_bits(input int from, input int gapmax, input bit glitch);
    int h;
    int l;
    for (int i = from; i < bits.size(); i++) begin
      if (bits[i]) h = $urandom_range(int'(thr) + 3, int'(thr));
      else         h = glitch ? 1 : $urandom_range(int'(thr) - 1, 1);
      l = $urandom_range(gapmax, 1);
      pulse(h, l);
    end
  endtask

  task automatic end_frame();
    repeat (int'(rt) + 8) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_addr", 32'(wr_addr), 32'd0);
    chk("rst_data", 32'(wr_data), 32'd0);
    chk("rst_be", 32'(wr_be), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Directed pixel G=12 R=34 B=56 with fixed pulse shapes
    thr = 8'd4; rt = 16'd64;
    bits.delete();
    add_byte(8'h12); add_byte(8'h34); add_byte(8'h56);
    foreach (bits[i]) pulse(bits[i] ? 6 : 2, bits[i] ? 4 : 8);
    repeat (100) @(negedge clk);
    model(1'b1);
    check_frame("t1");

    // Random frames, random thresholds and pulse widths, often with a partial trailing byte
    for (int f = 0; f < 4; f++) begin
      thr = 8'($urandom_range(6, 2));
      rt  = 16'($urandom_range(40, 12));
      bits.delete();
      add_rand_bits($urandom_range(60, 1));
      send_bits(0, int'(rt) - 1, 1'b0);
      end_frame();
      model(1'b1);
      check_frame($sformatf("rnd%0d", f));
    end

    // 13 bits: one G byte, rest dropped; next frame restarts at pixel 0 lane G
    thr = 8'd4; rt = 16'd32;
    bits.delete();
    add_rand_bits(13);
    send_bits(0, 10, 1'b0);
    end_frame();
    model(1'b1);
    check_frame("part");
    bits.delete();
    add_rand_bits(24);
    send_bits(0, 10, 1'b0);
    end_frame();
    model(1'b1);
    check_frame("after_part");

    // 257 pixels of 0xFF: last pixel dropped, overflow set
    thr = 8'd2; rt = 16'd16;
    bits.delete();
    for (int i = 0; i < 257 * 24; i++) bits.push_back(1'b1);
    foreach (bits[i]) pulse(2, 1);
    end_frame();
    model(1'b1);
    check_frame("ovfl");

    // Overflow clears on the first rise of the next frame
    bits.delete();
    bits.push_back(1'b1);
    add_rand_bits(7);
    line = 1'b1;
    repeat (5) @(negedge clk);
    chk("ovf_clear", 32'(ovf), 32'd0);
    line = 1'b0;
    repeat (2) @(negedge clk);
    send_bits(1, 10, 1'b0);
    end_frame();
    model(1'b1);
    check_frame("post_ovfl");

    // Reset mid-frame after two bytes: no done, new pixel restarts at address 0
    thr = 8'd4; rt = 16'd64;
    bits.delete();
    add_rand_bits(16);
    send_bits(0, 10, 1'b0);
    repeat (6) @(negedge clk);
    model(1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_data", 32'(wr_data), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    bits.delete();
    add_rand_bits(24);
    send_bits(0, 10, 1'b0);
    end_frame();
    model(1'b1);
    check_frame("rst_abort");

    // Low gaps exactly equal to rst_time: rise wins, frame continues
    thr = 8'd4; rt = 16'd20;
    bits.delete();
    add_rand_bits(24);
    foreach (bits[i])
      pulse(bits[i] ? 5 : 2, (i % 8 == 3) ? int'(rt) : $urandom_range(int'(rt) - 1, 1));
    end_frame();
    model(1'b1);
    check_frame("exact_gap");

    // 1-clk highs decode as 0 bits in the unfiltered build
    thr = 8'd4; rt = 16'd32;
    bits.delete();
    add_rand_bits(16);
    send_bits(0, 12, 1'b1);
    end_frame();
    model(1'b1);
    check_frame("glitch");

    chk("done_wr_overlap", 32'(overlap), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
